// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched: write-back scheduler for a 16 x 16-bit register file with a
// single write port. Two requesters (0 = ALU, 1 = load/memory) are arbitrated
// onto the port. req1 normally wins. req0 is forced ahead once it has waited
// MAX_WAIT cycles. A pending-write scoreboard (busy) lets issue logic stall on
// RAW hazards.
// Optional feature macro: RF_R0_ZERO_EN (register 0 hardwired to zero).
module regfile_wb_sched #(
  parameter int MAX_WAIT = 3,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [3:0]  req0_addr,
  input  logic [15:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [3:0]  req1_addr,
  input  logic [15:0] req1_data,
  output logic        req1_ready,
  input  logic        mark_valid,
  input  logic [3:0]  mark_addr,
  output logic        rf_regWrite,
  output logic [3:0]  rf_wrAddr,
  output logic [15:0] rf_wrData,
  output logic [15:0] busy,
  output logic        starved
);

  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic [CNT_W-1:0] starve_cnt;
  logic             grant0;
  logic             grant1;
  logic             aged;
  logic             write_en;
  logic [3:0]       grant_addr;
  logic [15:0]      grant_data;
  logic [15:0]      busy_next;

  // Arbitration: req1 wins ties unless req0 has aged past MAX_WAIT; nothing is granted during reset
  always_comb begin
    aged       = (starve_cnt >= WAIT_LIMIT);
    grant0     = 1'b0;
    grant1     = 1'b0;
    if (!rst) begin
      if (req0_valid && (!req1_valid || aged)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
    req0_ready = grant0;
    req1_ready = grant1;
    starved    = grant0 && req1_valid && aged;
    grant_addr = grant0 ? req0_addr : req1_addr;
    grant_data = grant0 ? req0_data : req1_data;
`ifdef RF_R0_ZERO_EN
    write_en   = (grant0 || grant1) && (grant_addr != 4'd0);
`else
    write_en   = grant0 || grant1;
`endif
  end

  // Starvation counter: counts consecutive refused cycles of a valid req0, saturating
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!req0_valid || grant0) begin
      starve_cnt <= '0;
    end else if (starve_cnt != CNT_MAX) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Write port register: one cycle after a grant the port carries the granted write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_regWrite <= 1'b0;
      rf_wrAddr   <= '0;
      rf_wrData   <= '0;
    end else begin
      rf_regWrite <= write_en;
      if (write_en) begin
        rf_wrAddr <= grant_addr;
        rf_wrData <= grant_data;
      end
    end
  end

  // Scoreboard next state: a grant retires its register, a new mark sets it and wins a collision
  always_comb begin
    busy_next = busy;
    if (grant0 || grant1) begin
      busy_next[grant_addr] = 1'b0;
    end
`ifdef RF_R0_ZERO_EN
    if (mark_valid && (mark_addr != 4'd0)) begin
      busy_next[mark_addr] = 1'b1;
    end
`else
    if (mark_valid) begin
      busy_next[mark_addr] = 1'b1;
    end
`endif
  end

  // Scoreboard register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

endmodule
